// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: chain of pipeline stage registers with per-stage valid,
// backward-propagating stall, per-stage flush, bubble insertion and debug counters.
module pipe_stage_chain #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned STAGES = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic                       enable,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    input  logic [STAGES-1:0]          hold,
    input  logic [STAGES-1:0]          flush,
    output logic [STAGES*DATA_W-1:0]   stage_data,
    output logic [STAGES-1:0]          stage_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    output logic [$clog2(STAGES+1)-1:0] occupancy,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic [CNT_W-1:0]           flush_cnt
);

    localparam int unsigned OCC_W = $clog2(STAGES + 1);

    logic [DATA_W-1:0] data_q   [STAGES];
    logic [DATA_W-1:0] src_data [STAGES];
    logic [DATA_W-1:0] nxt_data [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] src_valid;
    logic [STAGES-1:0] nxt_valid;
    logic [STAGES-1:0] stall;
    logic [STAGES-1:0] bubble;

    // A hold at stage j stalls that stage and every earlier one.
    always_comb begin
        stall = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            stall[k] = |(hold >> k);
        end
    end

    // A stage whose predecessor is stalled (and is itself free) receives a bubble.
    always_comb begin
        bubble = {stall[STAGES-2:0], 1'b0};
    end

    // Upstream source of each stage: the input port for stage 0, else the previous stage.
    always_comb begin
        src_valid    = '0;
        src_valid[0] = in_valid;
        src_data[0]  = in_valid ? in_data : '0;
        for (int unsigned k = 1; k < STAGES; k++) begin
            src_valid[k] = valid_q[k-1];
            src_data[k]  = data_q[k-1];
        end
    end

    // Next-state selection per stage: flush > stall > bubble > advance.
    always_comb begin
        nxt_valid = valid_q;
        for (int unsigned k = 0; k < STAGES; k++) begin
            nxt_data[k] = data_q[k];
            if (flush[k]) begin
                nxt_valid[k] = 1'b0;
                nxt_data[k]  = '0;
            end else if (stall[k]) begin
                nxt_valid[k] = valid_q[k];
                nxt_data[k]  = data_q[k];
            end else if (bubble[k]) begin
                nxt_valid[k] = 1'b0;
                nxt_data[k]  = '0;
            end else begin
                nxt_valid[k] = src_valid[k];
                nxt_data[k]  = src_data[k];
            end
        end
    end

    // Stage registers; the whole chain freezes when enable is low.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            valid_q <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
            end
        end else if (enable) begin
            valid_q <= nxt_valid;
            for (int unsigned k = 0; k < STAGES; k++) begin
                data_q[k] <= nxt_data[k];
            end
        end
    end

    // Saturating debug counters for stall and flush activity.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (enable) begin
            if ((|hold) && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if ((|flush) && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    // Occupancy is a popcount of the registered valid bits.
    always_comb begin
        occupancy = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            occupancy = occupancy + OCC_W'(valid_q[k]);
        end
    end

    // Flatten stage payloads onto the debug bus.
    always_comb begin
        stage_data = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            stage_data[k*DATA_W +: DATA_W] = data_q[k];
        end
    end

    // Direct views of the chain state and the input handshake.
    always_comb begin
        stage_valid = valid_q;
        out_data    = data_q[STAGES-1];
        out_valid   = valid_q[STAGES-1];
        in_ready    = enable & ~stall[0];
    end

endmodule
